// File: rtl/reg_ring_master_pkg.sv
// reg_ring_master_pkg: shared widths, unacked-data marker and FSM encoding for the ring master
package reg_ring_master_pkg;
  localparam int UDP_REG_ADDR_WIDTH = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam logic [31:0] UNACK_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/reg_ring_master.sv
// reg_ring_master: issues one host command onto the register ring and reports its return or timeout
module reg_ring_master
  import reg_ring_master_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_rd_wr_L,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] cmd_wr_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_data,
  output logic                           rsp_ack,
  output logic                           rsp_timeout,
  output logic [7:0]                     stray_cnt,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC = UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t                           state;
  logic                             rd_q;
  logic [UDP_REG_ADDR_WIDTH-1:0]    addr_q;
  logic [CPCI_NF2_DATA_WIDTH-1:0]   data_q;
  logic [15:0]                      cnt;
  logic                             match;
  logic                             stray;
  logic                             unused_rd_wr_in;
  assign reg_ack_out = 1'b0;
  assign unused_rd_wr_in = reg_rd_wr_L_in;
  assign match = reg_req_in && reg_src_in == SRC && reg_addr_in == addr_q;
  // anything coming back that is not our own return while waiting is discarded
  assign stray = reg_req_in && !(state == WAIT && match);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      rd_q            <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      cnt             <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_ack         <= 1'b0;
      rsp_timeout     <= 1'b0;
      stray_cnt       <= '0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      if (stray && stray_cnt != 8'hff) stray_cnt <= stray_cnt + 8'd1;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          rd_q            <= cmd_rd_wr_L;
          addr_q          <= cmd_addr;
          data_q          <= cmd_wr_data;
          cmd_ready       <= 1'b0;
          reg_req_out     <= 1'b1;
          reg_rd_wr_L_out <= cmd_rd_wr_L;
          reg_addr_out    <= cmd_addr;
          reg_data_out    <= cmd_wr_data;
          reg_src_out     <= SRC;
          state           <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (match) begin
          rsp_valid   <= 1'b1;
          rsp_ack     <= reg_ack_in;
          rsp_timeout <= 1'b0;
          rsp_data    <= !reg_ack_in ? UNACK_DATA : rd_q ? reg_data_in : data_q;
          state       <= RESP;
        end else if (cnt == LAST) begin
          rsp_valid   <= 1'b1;
          rsp_ack     <= 1'b0;
          rsp_timeout <= 1'b1;
          rsp_data    <= UNACK_DATA;
          state       <= RESP;
        end else begin
          cnt <= cnt + 16'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_ring_master.sv
// tb_reg_ring_master: loopback ring with a 3-stage responder, timestamp-based reference model and random traffic
module tb_reg_ring_master;
  import reg_ring_master_pkg::*;
  localparam int TO  = 16;
  localparam int SID = 1;

  typedef struct packed {
    logic        req;
    logic        ack;
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
  } ring_t;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_rd_wr_L = 0, rsp_ready = 0;
  logic [22:0] cmd_addr = '0;
  logic [31:0] cmd_wr_data = '0;
  logic        cmd_ready, rsp_valid, rsp_ack, rsp_timeout;
  logic [31:0] rsp_data;
  logic [7:0]  stray_cnt;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;

  reg_ring_master #(.UDP_REG_SRC_WIDTH(2), .SRC_ID(SID), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr_L(cmd_rd_wr_L),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ack(rsp_ack), .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  // ring: stage 1 is the responder (mode 0 acks addr < 0x400, mode 1 passes unacked, mode 2 drops)
  int    mode = 0;
  logic  inj_en = 0;
  ring_t inj = '0;
  ring_t s1, s2, s3, rin;
  logic [31:0] mem [1024];
  bit          wv [1024];
  logic        hit_resp;
  logic [9:0]  idx;
  assign idx = reg_addr_out[9:0];
  assign hit_resp = reg_req_out && mode == 0 && reg_addr_out < 23'h400;

  function automatic logic [31:0] dflt(input logic [9:0] a);
    return a == 10'h100 ? 32'h12345678 : {22'h2b5, a};
  endfunction

  always_ff @(posedge clk) begin
    s1.req  <= reg_req_out && mode != 2;
    s1.ack  <= reg_ack_out || hit_resp;
    s1.rw   <= reg_rd_wr_L_out;
    s1.addr <= reg_addr_out;
    s1.src  <= reg_src_out;
    s1.data <= !hit_resp ? reg_data_out : reg_rd_wr_L_out ? (wv[idx] ? mem[idx] : dflt(idx)) : ~reg_data_out;
    if (hit_resp && !reg_rd_wr_L_out) begin
      mem[idx] <= reg_data_out;
      wv[idx]  <= 1'b1;
    end
    s2 <= s1;
    s3 <= s2;
  end

  assign rin = inj_en ? inj : s3;
  assign reg_req_in = rin.req;
  assign reg_ack_in = rin.ack;
  assign reg_rd_wr_L_in = rin.rw;
  assign reg_addr_in = rin.addr;
  assign reg_data_in = rin.data;
  assign reg_src_in = rin.src;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // reference model: one open transaction described by its accept cycle and its outcome
  bit          m_open = 0, m_got = 0, m_valid = 0, m_ack = 0, m_to = 0, m_rd = 0;
  int          t_acc = 0;
  int          m_stray = 0;
  logic [22:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_data = '0;

  always @(negedge clk) begin
    bit er, hit;
    if (reset) begin
      m_open = 0; m_got = 0; m_valid = 0; m_stray = 0;
    end
    er = m_open && cyc == t_acc + 1;
    chk("cmd_ready", cmd_ready, !m_open);
    chk("reg_req_out", reg_req_out, er);
    chk("reg_ack_out", reg_ack_out, 0);
    chk("reg_rd_wr_L_out", reg_rd_wr_L_out, er ? m_rd : 1'b0);
    chk("reg_addr_out", reg_addr_out, er ? m_addr : 23'h0);
    chk("reg_data_out", reg_data_out, er ? m_wdata : 32'h0);
    chk("reg_src_out", reg_src_out, er ? 2'(SID) : 2'h0);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("stray_cnt", stray_cnt, m_stray);
    if (m_valid || reset) begin
      chk("rsp_ack", rsp_ack, m_ack && !reset);
      chk("rsp_timeout", rsp_timeout, m_to && !reset);
      chk("rsp_data", rsp_data, reset ? 32'h0 : m_data);
    end
    if (!reset) begin
      hit = 0;
      if (!m_open) begin
        if (cmd_valid) begin
          m_open = 1; m_got = 0; t_acc = cyc;
          m_rd = cmd_rd_wr_L; m_addr = cmd_addr; m_wdata = cmd_wr_data;
        end
      end else if (!m_got) begin
        if (cyc >= t_acc + 2) begin
          if (reg_req_in && reg_src_in == 2'(SID) && reg_addr_in == m_addr) begin
            hit = 1; m_got = 1; m_valid = 1; m_ack = reg_ack_in; m_to = 0;
            m_data = !reg_ack_in ? UNACK_DATA : m_rd ? reg_data_in : m_wdata;
          end else if (cyc == t_acc + 1 + TO) begin
            m_got = 1; m_valid = 1; m_ack = 0; m_to = 1; m_data = UNACK_DATA;
          end
        end
      end else if (rsp_ready) begin
        m_open = 0; m_valid = 0;
      end
      if (reg_req_in === 1'b1 && !hit && m_stray < 255) m_stray++;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic rw, input logic [22:0] a, input logic [31:0] d, output int ta);
    int n = 0;
    logic r;
    cmd_valid = 1; cmd_rd_wr_L = rw; cmd_addr = a; cmd_wr_data = d;
    do begin
      r = cmd_ready;
      tick;
      n++;
    end while (!r && n < 50);
    cmd_valid = 0;
    ta = cyc - 1;
    if (!r) chk("cmd_accept_bound", 0, 1);
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic a, output logic t, output int vc);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr = 23'($urandom);
      tick;
      n++;
    end
    cmd_valid = 0;
    if (n >= 200) chk("rsp_valid_bound", 0, 1);
    vc = cyc; d = rsp_data; a = rsp_ack; t = rsp_timeout;
    repeat ($urandom_range(0, 3)) tick;
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
  endtask

  task automatic inject(input logic [1:0] src, input logic [22:0] a);
    inj = '0; inj.req = 1; inj.src = src; inj.addr = a;
    inj_en = 1;
    tick;
    inj_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int ta, vc, r;
    logic [31:0] d;
    logic a, t;
    repeat (5) tick;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_stray", stray_cnt, 0);
    reset = 0;
    tick;
    // read of a responder-acked address
    mode = 0;
    do_cmd(1, 23'h000100, 32'h0, ta);
    get_rsp(d, a, t, vc);
    chk("rd_data", d, 32'h12345678); chk("rd_ack", a, 1); chk("rd_to", t, 0);
    chk("rd_latency", vc, ta + 5);
    // write then read back
    do_cmd(0, 23'h000123, 32'hCAFEF00D, ta);
    get_rsp(d, a, t, vc);
    chk("wr_data", d, 32'hCAFEF00D); chk("wr_ack", a, 1); chk("wr_to", t, 0);
    do_cmd(1, 23'h000123, 32'h0, ta);
    get_rsp(d, a, t, vc);
    chk("rdback_data", d, 32'hCAFEF00D);
    // unacked return
    mode = 1;
    do_cmd(1, 23'h000100, 32'h1, ta);
    get_rsp(d, a, t, vc);
    chk("unack_data", d, 32'hDEADBEEF); chk("unack_ack", a, 0); chk("unack_to", t, 0);
    // dropped request times out, late return is stray
    mode = 2;
    do_cmd(1, 23'h000040, 32'h2, ta);
    get_rsp(d, a, t, vc);
    chk("to_latency", vc, ta + 2 + TO);
    chk("to_flag", t, 1); chk("to_ack", a, 0); chk("to_data", d, 32'hDEADBEEF);
    inject(2'(SID), 23'h000040);
    tick;
    chk("late_stray", stray_cnt, 1);
    // foreign-tag return during WAIT, then the real one
    mode = 0;
    do_cmd(1, 23'h000200, 32'h0, ta);
    tick;
    inject(2'(SID + 1), 23'h000200);
    get_rsp(d, a, t, vc);
    chk("foreign_stray", stray_cnt, 2);
    chk("foreign_data", d, {22'h2b5, 10'h200}); chk("foreign_ack", a, 1);
    // stray counter saturation
    repeat (300) inject(2'(SID), 23'h7fffff);
    tick;
    chk("stray_sat", stray_cnt, 255);
    // reset during WAIT, in-flight return arrives afterwards
    do_cmd(1, 23'h000100, 32'h0, ta);
    tick;
    reset = 1;
    tick;
    reset = 0;
    repeat (4) tick;
    chk("post_reset_stray", stray_cnt, 1);
    chk("post_reset_ready", cmd_ready, 1);
    do_cmd(0, 23'h000300, 32'h0BADF00D, ta);
    get_rsp(d, a, t, vc);
    chk("post_reset_wr", d, 32'h0BADF00D); chk("post_reset_ack", a, 1);
    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 8);
      mode = r < 6 ? 0 : r < 8 ? 1 : 2;
      repeat ($urandom_range(0, 3)) begin
        inj = ring_t'(60'({$urandom(), $urandom()}));
        inj.req = 1;
        inj_en = ($urandom_range(0, 3) == 0);
        tick;
        inj_en = 0;
      end
      do_cmd(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'($urandom_range(0, 1023)),
             $urandom, ta);
      get_rsp(d, a, t, vc);
    end
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
